eth_phy_mdio_slave: RTL and testbench
=====================================

Name: eth_phy_mdio_slave

Overview:
- Clause-22 MDIO responder: the PHY-side end of the MDIO management interface driven by eth_mac_mdio.
- Oversamples an externally generated MDC in the aclk domain, decodes read/write frames addressed to its PHY address, and serves a local 32 x 16-bit register bank.
- Used as a bench PHY model and as a synthesizable management slave.

Parameters:
- PHY_ADDR, 5'd0, PHY address this slave answers to.
- PREAMBLE_MIN, 32, minimum consecutive 1 bits required before ST; range 1..32.
- SIM_DELAY, 1, delay applied to register updates (simulation only).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- mdc  in  1  MDIO clock from master; asynchronous to aclk.
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO pad output value.
- mdio_t  out  1  tri-state control: 1 = input (released), 0 = output.
- usr_rd_addr  in  5  local read address into the register bank.
- usr_rd_data  out  16  combinational read of bank[usr_rd_addr].
- reg_wr_pulse  out  1  one-cycle pulse when an MDIO write commits.
- reg_wr_addr  out  5  register address of the committed write.
- reg_wr_data  out  16  data of the committed write.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- busy  out  1  high from a valid ST until the frame ends or aborts.

Behaviour:
- Reset values:
  - mdio_t=1, mdio_o=1.
  - All bank registers 16'h0000.
  - reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0, frame_err=0, busy=0.
  - FSM in PRE; preamble count 0.
- Reset mid-frame immediately releases MDIO and discards the frame.
- Synchronization:
  - mdc and mdio_i pass through the same 2-flop synchronizer.
  - A third register on synchronized mdc detects the rising edge ("tick").
  - mdio is sampled only on a tick.
- Drive timing:
  - mdio_o/mdio_t are registered and update on the cycle of the tick, i.e. 3 aclk after the raw MDC rise.
  - Requirement: MDC high and low phases each >= 2 aclk (mdc_div_rate >= 1 at the master).
- Bit order: MSB first for all fields. Frame sequence is PRE, ST(01), OP, PHYAD, REGAD, TA, DATA.
- FSM states and transitions (one bit per tick):
  - PRE: a 1 increments the count, saturating at 32. A 0 with count >= PREAMBLE_MIN goes to ST2 and sets busy; a 0 with count < PREAMBLE_MIN clears the count.
  - ST2: expects 1; else frame_err and go to PRE.
  - OP: 2 bits; 10 = read, 01 = write. 00 or 11 gives frame_err and go to PRE.
  - PHYAD: 5 bits, then REGAD: 5 bits. The PHYAD compare is done at the end of REGAD. On mismatch, go to PRE silently (no error, never drive), busy=0.
  - TA for a read:
    - Tick that samples REGAD[0]: keep mdio_t=1.
    - Next tick: mdio_t=0, mdio_o=0.
    - Next tick: drive bank[REGAD][15] and enter RD.
  - TA for a write: sampled bits must be 1 then 0; otherwise frame_err and go to PRE.
  - RD: each tick shifts out the next bit down to bit 0. The tick after bit 0 was driven sets mdio_t=1, mdio_o=1 and goes to PRE.
  - WR: shifts in 16 bits. On the 16th bit, in the same cycle: write the bank, set reg_wr_pulse=1, latch reg_wr_addr/reg_wr_data, go to PRE.
- Read data snapshot: read data is captured into a shift register at the second TA tick. A local write is not possible, so the bank is stable during the frame.
- Preamble after a frame:
  - The count restarts at 0 on return to PRE; the next frame needs a new preamble.
  - Back-to-back frames with PREAMBLE_MIN=32 require 32 ones.
- A frame_err never corrupts the bank; mdio_t is forced to 1 on any abort.

Test Plan:
- Reset with MDC toggling -> mdio_t=1, busy=0, usr_rd_data=0 for all addresses; reset asserted mid-RD -> mdio_t=1 within the reset edge.
- PHY_ADDR=5'b01101; master writes phy 5'b01101, reg 5'b10100, data 16'hCC3B (mdc_div_rate=1) -> reg_wr_pulse once, reg_wr_addr=20, reg_wr_data=16'hCC3B; usr_rd_addr=20 reads 16'hCC3B.
- Then master reads phy 5'b01101, reg 5'b10100:
  - mdio_t=1 during TA bit 1, 0 from TA bit 2 for 17 MDC periods.
  - Master mdio_access_rdata=16'hCC3B; mdio_t=1 after the frame.
- Master accesses phy 5'b11100 -> mdio_t stays 1 the entire frame; no reg_wr_pulse; no frame_err.
- Preamble of 31 ones then 01 with PREAMBLE_MIN=32 -> frame ignored, busy stays 0; write with TA=11 -> frame_err pulse, bank unchanged.
- OP=11 after a valid preamble -> frame_err; the immediately following valid read (new preamble) returns correct data.

Source files
------------

// File: rtl/eth_phy_mdio_slave.sv
// Clause-22 MDIO responder: oversamples MDC in the aclk domain, decodes frames for PHY_ADDR
// and serves a 32 x 16-bit register bank. SIM_DELAY is kept for interface compatibility only.
module eth_phy_mdio_slave #(
    parameter logic [4:0] PHY_ADDR     = 5'd0,
    parameter int         PREAMBLE_MIN = 32,
    parameter int         SIM_DELAY    = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic [4:0]  usr_rd_addr,
    output logic [15:0] usr_rd_data,
    output logic        reg_wr_pulse,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_PRE,
        S_ST2,
        S_OP,
        S_ADDR,
        S_TA,
        S_RD,
        S_WR
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    logic        r_mdc_s1, r_mdc_s2, r_mdc_s3;
    logic        r_mdio_s1, r_mdio_s2;
    logic        w_tick;
    logic        w_bit;

    state_t      r_state, w_state;
    logic [5:0]  r_pre_cnt, w_pre_cnt;
    logic [3:0]  r_cnt, w_cnt;
    logic [1:0]  r_op, w_op;
    logic [8:0]  r_addr, w_addr;
    logic [9:0]  w_addr_full;
    logic [4:0]  r_regad, w_regad;
    logic [15:0] r_shift, w_shift;
    logic        r_mdio_o, w_mdio_o;
    logic        r_mdio_t, w_mdio_t;
    logic        r_wr_pulse, w_wr_pulse;
    logic [4:0]  r_wr_addr, w_wr_addr;
    logic [15:0] r_wr_data, w_wr_data;
    logic        r_frame_err, w_frame_err;
    logic        w_bank_we;
    logic [15:0] r_bank [32];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mdc_s1  <= 1'b0;
            r_mdc_s2  <= 1'b0;
            r_mdc_s3  <= 1'b0;
            r_mdio_s1 <= 1'b1;
            r_mdio_s2 <= 1'b1;
        end else begin
            r_mdc_s1  <= mdc;
            r_mdc_s2  <= r_mdc_s1;
            r_mdc_s3  <= r_mdc_s2;
            r_mdio_s1 <= mdio_i;
            r_mdio_s2 <= r_mdio_s1;
        end
    end

    assign w_tick      = r_mdc_s2 & ~r_mdc_s3;
    assign w_bit       = r_mdio_s2;
    assign w_addr_full = {r_addr, w_bit};

    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    always_comb begin
        w_state     = r_state;
        w_pre_cnt   = r_pre_cnt;
        w_cnt       = r_cnt;
        w_op        = r_op;
        w_addr      = r_addr;
        w_regad     = r_regad;
        w_shift     = r_shift;
        w_mdio_o    = r_mdio_o;
        w_mdio_t    = r_mdio_t;
        w_wr_pulse  = 1'b0;
        w_wr_addr   = r_wr_addr;
        w_wr_data   = r_wr_data;
        w_frame_err = 1'b0;
        w_bank_we   = 1'b0;

        if (w_tick) begin
            case (r_state)
                S_PRE: begin
                    if (w_bit) begin
                        if (r_pre_cnt != 6'd32) begin
                            w_pre_cnt = r_pre_cnt + 6'd1;
                        end
                    end else begin
                        if (r_pre_cnt >= PRE_MIN) begin
                            w_state = S_ST2;
                        end
                        w_pre_cnt = 6'd0;
                    end
                end
                S_ST2: begin
                    if (w_bit) begin
                        w_state = S_OP;
                        w_cnt   = 4'd0;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state     = S_PRE;
                    end
                end
                S_OP: begin
                    w_op = {r_op[0], w_bit};
                    if (r_cnt == 4'd0) begin
                        w_cnt = 4'd1;
                    end else if (w_op == 2'b10 || w_op == 2'b01) begin
                        w_state = S_ADDR;
                        w_cnt   = 4'd0;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state     = S_PRE;
                    end
                end
                S_ADDR: begin
                    w_addr = w_addr_full[8:0];
                    if (r_cnt == 4'd9) begin
                        // Foreign PHY address: drop back to PRE without flagging an error.
                        if (w_addr_full[9:5] == PHY_ADDR) begin
                            w_regad = w_addr_full[4:0];
                            w_state = S_TA;
                            w_cnt   = 4'd0;
                        end else begin
                            w_state = S_PRE;
                        end
                    end else begin
                        w_cnt = r_cnt + 4'd1;
                    end
                end
                S_TA: begin
                    if (r_op == 2'b10) begin
                        if (r_cnt == 4'd0) begin
                            w_mdio_t = 1'b0;
                            w_mdio_o = 1'b0;
                            w_shift  = r_bank[r_regad];
                            w_cnt    = 4'd1;
                        end else begin
                            w_mdio_o = r_shift[15];
                            w_shift  = {r_shift[14:0], 1'b0};
                            w_state  = S_RD;
                            w_cnt    = 4'd0;
                        end
                    end else begin
                        if (r_cnt == 4'd0 && w_bit) begin
                            w_cnt = 4'd1;
                        end else if (r_cnt == 4'd1 && !w_bit) begin
                            w_state = S_WR;
                            w_cnt   = 4'd0;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state     = S_PRE;
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == 4'd15) begin
                        w_state = S_PRE;
                    end else begin
                        w_mdio_o = r_shift[15];
                        w_shift  = {r_shift[14:0], 1'b0};
                        w_cnt    = r_cnt + 4'd1;
                    end
                end
                S_WR: begin
                    w_shift = {r_shift[14:0], w_bit};
                    if (r_cnt == 4'd15) begin
                        w_bank_we  = 1'b1;
                        w_wr_pulse = 1'b1;
                        w_wr_addr  = r_regad;
                        w_wr_data  = w_shift;
                        w_state    = S_PRE;
                    end else begin
                        w_cnt = r_cnt + 4'd1;
                    end
                end
                default: begin
                    w_state = S_PRE;
                end
            endcase
        end

        // The pad is released whenever the responder is idle, including after any abort.
        if (w_state == S_PRE) begin
            w_mdio_t = 1'b1;
            w_mdio_o = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_PRE;
            r_pre_cnt   <= 6'd0;
            r_cnt       <= 4'd0;
            r_op        <= 2'b00;
            r_addr      <= 9'd0;
            r_regad     <= 5'd0;
            r_shift     <= 16'h0000;
            r_mdio_o    <= 1'b1;
            r_mdio_t    <= 1'b1;
            r_wr_pulse  <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_wr_data   <= 16'h0000;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pre_cnt   <= w_pre_cnt;
            r_cnt       <= w_cnt;
            r_op        <= w_op;
            r_addr      <= w_addr;
            r_regad     <= w_regad;
            r_shift     <= w_shift;
            r_mdio_o    <= w_mdio_o;
            r_mdio_t    <= w_mdio_t;
            r_wr_pulse  <= w_wr_pulse;
            r_wr_addr   <= w_wr_addr;
            r_wr_data   <= w_wr_data;
            r_frame_err <= w_frame_err;
        end
    end

    // NOTE: the bank is architecturally visible after reset, so it is cleared rather than left as RAM.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 32; i++) begin
                r_bank[i] <= 16'h0000;
            end
        end else if (w_bank_we) begin
            r_bank[r_regad] <= w_shift;
        end
    end

    assign usr_rd_data  = r_bank[usr_rd_addr];
    assign mdio_o       = r_mdio_o;
    assign mdio_t       = r_mdio_t;
    assign reg_wr_pulse = r_wr_pulse;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;
    assign frame_err    = r_frame_err;
    assign busy         = (r_state != S_PRE);

endmodule

// File: tb/tb_eth_phy_mdio_slave.sv
// Self-checking bench: a bit-level MDIO master drives randomized frames and a frame-level
// reference model predicts the responder's reaction.
module tb_eth_phy_mdio_slave;

    localparam logic [4:0] PHY        = 5'b01101;
    localparam int         PRE_MIN    = 32;
    localparam int         MDC_PERIOD = 4;

    typedef enum {K_IGN, K_ERR, K_RD, K_WR} kind_t;
    typedef struct {
        int         pre;
        logic [1:0] st;
        logic [1:0] op;
        logic [4:0] phy;
        logic [4:0] ra;
        logic [1:0] ta;
        logic [15:0] data;
        int         idle;
    } frame_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        mdc = 1'b0;
    logic        m_oe = 1'b0;
    logic        m_val = 1'b1;
    logic [4:0]  usr_rd_addr = 5'd0;
    logic        mdio_line;
    logic        mdio_o, mdio_t;
    logic [15:0] usr_rd_data;
    logic        reg_wr_pulse;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_bank [32];

    int unsigned mon_wr = 0, mon_err = 0, mon_busy = 0, mon_drive = 0, mon_cont = 0;
    logic [4:0]  mon_wr_addr = 5'd0;
    logic [15:0] mon_wr_data = 16'h0000;

    int unsigned d_wr, d_err, d_busy, d_drive, d_cont;
    logic [18:0] r_tvec;
    logic [17:0] r_line;
    logic [15:0] r_rdata;

    assign mdio_line = !mdio_t ? mdio_o : (m_oe ? m_val : 1'b1);

    always #5 aclk = ~aclk;

    eth_phy_mdio_slave #(
        .PHY_ADDR    (PHY),
        .PREAMBLE_MIN(PRE_MIN),
        .SIM_DELAY   (1)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .mdc         (mdc),
        .mdio_i      (mdio_line),
        .mdio_o      (mdio_o),
        .mdio_t      (mdio_t),
        .usr_rd_addr (usr_rd_addr),
        .usr_rd_data (usr_rd_data),
        .reg_wr_pulse(reg_wr_pulse),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always @(posedge aclk) begin
        if (reg_wr_pulse) begin
            mon_wr++;
            mon_wr_addr = reg_wr_addr;
            mon_wr_data = reg_wr_data;
        end
        if (frame_err) mon_err++;
        if (busy) mon_busy++;
        if (!mdio_t) mon_drive++;
        if (!mdio_t && m_oe) mon_cont++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic kind_t predict(frame_t f, int prior_ones);
        if (prior_ones + f.pre < PRE_MIN) return K_IGN;
        if (f.st != 2'b01) return K_ERR;
        if (f.op != 2'b10 && f.op != 2'b01) return K_ERR;
        if (f.phy != PHY) return K_IGN;
        if (f.op == 2'b10) return K_RD;
        if (f.ta != 2'b10) return K_ERR;
        return K_WR;
    endfunction

    // One MDC period: master changes mdio on the fall, samples on the rise.
    task automatic mdc_bit(input logic oe, input logic val, output logic line_s, output logic t_s);
        @(negedge aclk);
        mdc   = 1'b0;
        m_oe  = oe;
        m_val = val;
        @(negedge aclk);
        @(negedge aclk);
        mdc    = 1'b1;
        line_s = mdio_line;
        t_s    = mdio_t;
        @(negedge aclk);
    endtask

    task automatic run_frame(input frame_t f, input int abort_at);
        logic [31:0] w;
        logic        l, t, b, oe;
        int unsigned s_wr, s_err, s_busy, s_drive, s_cont;
        int          base, n, k;
        bit          rd;
        s_wr = mon_wr; s_err = mon_err; s_busy = mon_busy; s_drive = mon_drive; s_cont = mon_cont;
        w      = {f.st, f.op, f.phy, f.ra, f.ta, f.data};
        rd     = (f.op == 2'b10);
        base   = f.pre + 14;
        n      = f.pre + 32 + f.idle;
        r_tvec = '1;
        r_line = '1;
        for (int i = 0; i < n; i++) begin
            oe = 1'b1;
            k  = i - f.pre;
            if (i < f.pre) b = 1'b1;
            else if (k < 32) b = w[31-k];
            else begin
                b  = 1'b1;
                oe = 1'b0;
            end
            if (rd && i >= base) oe = 1'b0;
            mdc_bit(oe, b, l, t);
            if (i >= base && i < base + 19) begin
                r_tvec[i-base] = t;
                if (i - base < 18) r_line[i-base] = l;
            end
            if (i == abort_at) return;
        end
        m_oe = 1'b0;
        repeat (6) @(negedge aclk);
        for (int j = 0; j < 16; j++) r_rdata[15-j] = r_line[2+j];
        d_wr = mon_wr - s_wr; d_err = mon_err - s_err; d_busy = mon_busy - s_busy;
        d_drive = mon_drive - s_drive; d_cont = mon_cont - s_cont;
    endtask

    task automatic test_reset();
        logic l, t;
        aresetn = 1'b0;
        for (int i = 0; i < 6; i++) mdc_bit(1'b1, 1'($urandom_range(0, 1)), l, t);
        m_oe = 1'b0;
        checks++;
        if (mdio_t !== 1'b1 || mdio_o !== 1'b1) begin
            errors++; $display("FAIL reset_pad: mdio_t=%b mdio_o=%b expected 1/1", mdio_t, mdio_o);
        end
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0 || reg_wr_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy=%b err=%b pulse=%b expected 0", busy, frame_err, reg_wr_pulse);
        end
        checks++;
        if (reg_wr_addr !== 5'd0 || reg_wr_data !== 16'h0000) begin
            errors++; $display("FAIL reset_wr_regs: addr=%0d data=%h expected 0", reg_wr_addr, reg_wr_data);
        end
        for (int a = 0; a < 32; a++) begin
            usr_rd_addr = 5'(a);
            #1;
            checks++;
            if (usr_rd_data !== 16'h0000) begin
                errors++; $display("FAIL reset_bank[%0d]: got %h expected 0000", a, usr_rd_data);
            end
        end
        for (int a = 0; a < 32; a++) m_bank[a] = 16'h0000;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_write_read();
        frame_t f;
        logic   ok;
        f = '{pre: 32, st: 2'b01, op: 2'b01, phy: PHY, ra: 5'b10100, ta: 2'b10, data: 16'hCC3B, idle: 0};
        run_frame(f, -1);
        m_bank[20] = 16'hCC3B;
        checks++;
        if (d_wr !== 1 || mon_wr_addr !== 5'd20 || mon_wr_data !== 16'hCC3B) begin
            errors++; $display("FAIL wr_commit: pulses=%0d addr=%0d data=%h expected 1/20/cc3b", d_wr, mon_wr_addr, mon_wr_data);
        end
        checks++;
        if (d_err !== 0 || d_busy == 0 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_flags: err=%0d busy_cycles=%0d busy=%b", d_err, d_busy, busy);
        end
        usr_rd_addr = 5'd20;
        #1;
        checks++;
        if (usr_rd_data !== 16'hCC3B) begin
            errors++; $display("FAIL wr_bank: got %h expected cc3b", usr_rd_data);
        end

        f.op = 2'b10; f.idle = 1;
        run_frame(f, -1);
        checks++;
        if (r_tvec[0] !== 1'b1 || r_tvec[1] !== 1'b0 || r_line[1] !== 1'b0) begin
            errors++; $display("FAIL rd_turnaround: t=%b%b line2=%b expected t=10 line2=0", r_tvec[0], r_tvec[1], r_line[1]);
        end
        ok = 1'b1;
        for (int j = 2; j < 18; j++) if (r_tvec[j] !== 1'b0) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rd_drive_window: mdio_t trace %b expected zeros in data", r_tvec);
        end
        checks++;
        if (r_rdata !== 16'hCC3B) begin
            errors++; $display("FAIL rd_data: got %h expected cc3b", r_rdata);
        end
        checks++;
        if (r_tvec[18] !== 1'b1 || mdio_t !== 1'b1) begin
            errors++; $display("FAIL rd_release: t_after=%b now=%b expected 1", r_tvec[18], mdio_t);
        end
        checks++;
        if (d_drive !== 17 * MDC_PERIOD || d_cont !== 0) begin
            errors++; $display("FAIL rd_drive_len: drive=%0d cont=%0d expected %0d/0", d_drive, d_cont, 17 * MDC_PERIOD);
        end
        checks++;
        if (d_err !== 0 || d_wr !== 0) begin
            errors++; $display("FAIL rd_flags: err=%0d wr=%0d expected 0/0", d_err, d_wr);
        end
    endtask

    task automatic test_other_phy();
        frame_t f;
        for (int op = 0; op < 2; op++) begin
            f = '{pre: 32, st: 2'b01, op: (op == 0) ? 2'b10 : 2'b01, phy: 5'b11100, ra: 5'b10100,
                  ta: 2'b10, data: 16'h1234, idle: 1};
            run_frame(f, -1);
            checks++;
            if (d_drive !== 0 || d_wr !== 0 || d_err !== 0 || busy !== 1'b0) begin
                errors++; $display("FAIL other_phy op%0d: drive=%0d wr=%0d err=%0d busy=%b expected 0", op, d_drive, d_wr, d_err, busy);
            end
        end
        usr_rd_addr = 5'd20;
        #1;
        checks++;
        if (usr_rd_data !== m_bank[20]) begin
            errors++; $display("FAIL other_phy_bank: got %h expected %h", usr_rd_data, m_bank[20]);
        end
    endtask

    task automatic test_short_preamble();
        frame_t f;
        f = '{pre: 32, st: 2'b01, op: 2'b01, phy: PHY, ra: 5'd3, ta: 2'b10, data: 16'h5A0F, idle: 0};
        run_frame(f, -1);
        m_bank[3] = 16'h5A0F;
        checks++;
        if (d_wr !== 1) begin
            errors++; $display("FAIL short_pre_setup: pulses=%0d expected 1", d_wr);
        end
        f = '{pre: 31, st: 2'b01, op: 2'b01, phy: PHY, ra: 5'd3, ta: 2'b10, data: 16'hFFFF, idle: 0};
        run_frame(f, -1);
        checks++;
        if (predict(f, 0) != K_IGN || d_busy !== 0 || d_err !== 0 || d_wr !== 0) begin
            errors++; $display("FAIL short_pre: busy_cycles=%0d err=%0d wr=%0d expected 0", d_busy, d_err, d_wr);
        end
        f = '{pre: 32, st: 2'b01, op: 2'b01, phy: PHY, ra: 5'd3, ta: 2'b11, data: 16'h0000, idle: 1};
        run_frame(f, -1);
        checks++;
        if (predict(f, 0) != K_ERR || d_err !== 1 || d_wr !== 0 || d_drive !== 0) begin
            errors++; $display("FAIL bad_ta: err=%0d wr=%0d drive=%0d expected 1/0/0", d_err, d_wr, d_drive);
        end
        usr_rd_addr = 5'd3;
        #1;
        checks++;
        if (usr_rd_data !== m_bank[3]) begin
            errors++; $display("FAIL bad_ta_bank: got %h expected %h", usr_rd_data, m_bank[3]);
        end
    endtask

    task automatic test_bad_op();
        frame_t f;
        f = '{pre: 32, st: 2'b01, op: 2'b11, phy: PHY, ra: 5'd3, ta: 2'b10, data: 16'hABCD, idle: 0};
        run_frame(f, -1);
        checks++;
        if (d_err !== 1 || d_wr !== 0 || d_drive !== 0) begin
            errors++; $display("FAIL bad_op: err=%0d wr=%0d drive=%0d expected 1/0/0", d_err, d_wr, d_drive);
        end
        f.op = 2'b10; f.idle = 1;
        run_frame(f, -1);
        checks++;
        if (r_rdata !== m_bank[3] || d_err !== 0 || d_cont !== 0) begin
            errors++; $display("FAIL bad_op_recover: got %h expected %h err=%0d", r_rdata, m_bank[3], d_err);
        end
    endtask

    task automatic test_random();
        frame_t f;
        kind_t  kd;
        int     r;
        for (int it = 0; it < 24; it++) begin
            r      = $urandom_range(0, 9);
            f.pre  = 32 + $urandom_range(0, 4);
            f.st   = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'b01;
            f.op   = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
            f.phy  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : PHY;
            f.ra   = 5'($urandom);
            f.ta   = ($urandom_range(0, 6) == 0) ? 2'($urandom) : 2'b10;
            f.data = 16'($urandom);
            f.idle = $urandom_range(0, 2);
            kd = predict(f, 0);
            run_frame(f, -1);
            checks++;
            case (kd)
                K_WR: begin
                    m_bank[f.ra] = f.data;
                    if (d_wr !== 1 || mon_wr_addr !== f.ra || mon_wr_data !== f.data || d_err !== 0) begin
                        errors++; $display("FAIL rand_wr it%0d: n=%0d addr=%0d data=%h expected 1/%0d/%h", it, d_wr, mon_wr_addr, mon_wr_data, f.ra, f.data);
                    end
                end
                K_RD: begin
                    if (r_rdata !== m_bank[f.ra] || d_drive !== 17 * MDC_PERIOD || d_err !== 0 || d_cont !== 0) begin
                        errors++; $display("FAIL rand_rd it%0d: got %h expected %h drive=%0d", it, r_rdata, m_bank[f.ra], d_drive);
                    end
                end
                K_ERR: begin
                    if (d_err !== 1 || d_wr !== 0 || d_drive !== 0) begin
                        errors++; $display("FAIL rand_err it%0d: err=%0d wr=%0d drive=%0d expected 1/0/0", it, d_err, d_wr, d_drive);
                    end
                end
                default: begin
                    if (d_err !== 0 || d_wr !== 0 || d_drive !== 0) begin
                        errors++; $display("FAIL rand_ign it%0d: err=%0d wr=%0d drive=%0d expected 0", it, d_err, d_wr, d_drive);
                    end
                end
            endcase
        end
        for (int a = 0; a < 32; a++) begin
            usr_rd_addr = 5'(a);
            #1;
            checks++;
            if (usr_rd_data !== m_bank[a]) begin
                errors++; $display("FAIL rand_bank[%0d]: got %h expected %h", a, usr_rd_data, m_bank[a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t f;
        logic [4:0]  regs [4];
        logic [15:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            regs[i] = 5'(8 + i);
            vals[i] = 16'($urandom);
            f = '{pre: 32, st: 2'b01, op: 2'b01, phy: PHY, ra: regs[i], ta: 2'b10, data: vals[i], idle: 0};
            run_frame(f, -1);
            m_bank[regs[i]] = vals[i];
        end
        for (int i = 0; i < 4; i++) begin
            f = '{pre: 32, st: 2'b01, op: 2'b10, phy: PHY, ra: regs[i], ta: 2'b10, data: 16'h0, idle: 0};
            run_frame(f, -1);
            checks++;
            if (r_rdata !== m_bank[regs[i]] || d_cont !== 0) begin
                errors++; $display("FAIL b2b_rd%0d: got %h expected %h cont=%0d", i, r_rdata, m_bank[regs[i]], d_cont);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        frame_t f;
        f = '{pre: 32, st: 2'b01, op: 2'b01, phy: PHY, ra: 5'd7, ta: 2'b10, data: 16'h8E71, idle: 0};
        run_frame(f, -1);
        m_bank[7] = 16'h8E71;
        f.op = 2'b10;
        run_frame(f, f.pre + 24);
        checks++;
        if (mdio_t !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_rd_driving: mdio_t=%b busy=%b expected 0/1", mdio_t, busy);
        end
        #2 aresetn = 1'b0;
        #1;
        usr_rd_addr = 5'd7;
        #1;
        checks++;
        if (mdio_t !== 1'b1 || busy !== 1'b0 || usr_rd_data !== 16'h0000) begin
            errors++; $display("FAIL mid_rd_reset: mdio_t=%b busy=%b bank7=%h expected 1/0/0000", mdio_t, busy, usr_rd_data);
        end
        for (int a = 0; a < 32; a++) m_bank[a] = 16'h0000;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        f.idle = 1;
        run_frame(f, -1);
        checks++;
        if (r_rdata !== m_bank[7] || r_tvec[18] !== 1'b1 || d_err !== 0) begin
            errors++; $display("FAIL post_reset_rd: got %h expected %h release=%b", r_rdata, m_bank[7], r_tvec[18]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_other_phy();
        test_short_preamble();
        test_bad_op();
        test_random();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
